inst_mem_ctrl: RTL
==================

Name: inst_mem_ctrl

Overview:
- Instruction-memory responder on the far end of the CPU fetch interface: accepts the chip-enable and instruction address, and returns a 32-bit instruction word one cycle later.
- Holds a single-port word RAM.
- Includes a byte-stream boot loader FSM that fills the RAM from address 0 before the core is released.
- Sits beside the cpu top, driven by its rom_ce_o/rom_addr_o; drives its rom_data_i.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
ce_i  input  1  fetch enable (cpu rom_ce_o)
addr_i  input  32  fetch byte address (cpu rom_addr_o)
inst_o  output  32  fetched instruction (cpu rom_data_i)
valid_o  output  1  inst_o holds a real fetch result
ld_start_i  input  1  single-cycle pulse: begin load session
ld_valid_i  input  1  loader byte valid
ld_byte_i  input  8  loader byte, big-endian within word
ld_last_i  input  1  qualifies final byte of session
ld_ready_o  output  1  loader may present bytes
ld_done_o  output  1  one-cycle pulse, session complete
ld_words_o  output  DEPTH_LOG2+1  words written in last/current session
ld_ovf_o  output  1  sticky: bytes dropped, RAM full

Behaviour:
- Reset (rst=0, async) sets:
  - FSM to IDLE.
  - inst_o=0, valid_o=0, ld_ready_o=0, ld_done_o=0, ld_words_o=0, ld_ovf_o=0.
  - Byte counter and word pointer to 0.
  - RAM contents are not cleared.
- FSM states:
  - IDLE: serve fetches. ld_start_i=1 -> LOAD; clears word pointer, byte counter, ld_words_o, ld_ovf_o. ld_ready_o goes high the cycle after entering LOAD.
  - LOAD: ld_ready_o=1. Each cycle with ld_valid_i=1 accepts ld_byte_i into an assembly register; the first byte lands in bits 31:24.
    - On the 4th byte, the word is written at the word pointer, the pointer increments, and ld_words_o increments.
    - ld_valid_i & ld_last_i: the current partial word (bytes not received = 0) is written if the byte counter after the accept is nonzero or the word just completed. The completed word is written once, not twice. Then -> DONE.
    - ld_start_i is ignored in LOAD.
  - DONE: ld_ready_o=0, ld_done_o=1 for exactly one cycle, -> IDLE.
- Overflow: a word write with the pointer == 2^DEPTH_LOG2 is suppressed and ld_ovf_o is set. Subsequent bytes are still accepted (drained) until ld_last_i. The pointer does not wrap.
- Fetch:
  - Word index = addr_i[DEPTH_LOG2+1:2]; addr_i[1:0] is ignored.
  - Out of range if any addr_i[31:DEPTH_LOG2+2] != 0.
  - Latency is 1 cycle, registered. In IDLE with ce_i=1: next cycle inst_o = RAM[index] (0 if out of range), valid_o=1.
  - ce_i=0: next cycle inst_o=0 (MIPS nop), valid_o=0.
  - In LOAD/DONE: inst_o=0, valid_o=0 regardless of ce_i, so no fetch can read a half-written RAM.
- Read-during-write cannot occur, because fetch is blocked outside IDLE.
- Reset mid-LOAD: returns to IDLE immediately. Words already written remain. The partial assembly word is discarded.

Optional Feature:
- Macro: INST_MEM_CHECKSUM_EN.
- Defined:
  - Adds output ld_sum_o [31:0]: the modulo-2^32 sum of every word actually written in the current session, padded partial words included.
  - Cleared on reset and on the IDLE->LOAD transition.
  - Final value is stable from the ld_done_o cycle.
- Undefined: the port and adder are absent. All other behaviour is identical.

Test Plan:
- Reset then ce_i=1, addr_i=0 -> inst_o=0, valid_o=0 while rst=0. After release, valid_o=1 one cycle after ce_i sampled.
- Load bytes 24 01 00 05 | 00 00 00 00 with last on the 8th byte -> ld_done_o one pulse, ld_words_o=2. Fetch addr 0x0 gives 0x24010005; addr 0x6 gives 0x00000000 (word 1, low bits ignored).
- Load 5 bytes AA BB CC DD EE, last on EE -> ld_words_o=2, RAM[1]=0xEE000000. With INST_MEM_CHECKSUM_EN, ld_sum_o=0x98BBCCDD.
- ce_i=1 during LOAD at addr 0 -> inst_o=0, valid_o=0 throughout. First valid fetch occurs the cycle after return to IDLE.
- Fetch addr_i=0x0000_1000 (DEPTH_LOG2=10) -> inst_o=0, valid_o=1.
- Stream 4*1024+4 bytes -> ld_words_o=1024, ld_ovf_o=1, RAM[0] unchanged by extra bytes. Assert rst mid-load of a 2nd session -> ld_ready_o=0 immediately, words written before reset readable.

Source files
------------

// File: rtl/inst_mem_ctrl.sv
// Instruction-memory responder: 1-cycle registered fetch from a word RAM, plus a
// byte-stream boot loader. Optional checksum output enabled by INST_MEM_CHECKSUM_EN.
module inst_mem_ctrl #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    output logic                  valid_o,
    input  logic                  ld_start_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_done_o,
    output logic [DEPTH_LOG2:0]   ld_words_o,
    output logic                  ld_ovf_o
`ifdef INST_MEM_CHECKSUM_EN
    ,
    output logic [31:0]           ld_sum_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t                state_reg;
    logic [31:0]           ram [DEPTH];
    logic [31:0]           ram_rd_reg;
    logic                  fetch_hit_reg;
    logic                  valid_reg;
    logic                  ready_reg;
    logic                  done_reg;
    logic                  ovf_reg;
    logic [DEPTH_LOG2:0]   ptr_reg;
    logic [1:0]            cnt_reg;
    logic [31:0]           asm_reg;
`ifdef INST_MEM_CHECKSUM_EN
    logic [31:0]           sum_reg;
`endif

    logic [31:0]           word_next;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic                  fetch_oor;
    logic                  fetch_en;
    logic                  accept;
    logic                  wr_word;
    logic                  ram_full;
    logic                  ram_we;
    logic                  unused_addr_lsb;

    assign fetch_idx       = addr_i[DEPTH_LOG2+1:2];
    assign fetch_oor       = |addr_i[31:DEPTH_LOG2+2];
    assign unused_addr_lsb = ^addr_i[1:0];
    assign fetch_en        = (state_reg == ST_IDLE) && ce_i;
    assign accept          = (state_reg == ST_LOAD) && ld_valid_i;
    // A last byte always leaves at least one byte pending (or a full word), so it always writes.
    assign wr_word         = accept && ((cnt_reg == 2'd3) || ld_last_i);
    assign ram_full        = ptr_reg[DEPTH_LOG2];
    assign ram_we          = wr_word && !ram_full;
    assign ram_addr        = (state_reg == ST_LOAD) ? ptr_reg[DEPTH_LOG2-1:0] : fetch_idx;

    // Byte lanes, big-endian: lane gi occupies bits 31-8*gi downto 24-8*gi.
    // Lanes not yet received in the current word read as zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign word_next[31-8*gi -: 8] =
                (cnt_reg == 2'(gi)) ? ld_byte_i :
                (cnt_reg >  2'(gi)) ? asm_reg[31-8*gi -: 8] : 8'h00;
        end
    endgenerate

    // Single-port RAM: loader writes only in LOAD, fetch reads only in IDLE.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= word_next;
        end
        if (fetch_en) begin
            ram_rd_reg <= ram[ram_addr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            fetch_hit_reg <= 1'b0;
            valid_reg     <= 1'b0;
            ready_reg     <= 1'b0;
            done_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            ptr_reg       <= '0;
            cnt_reg       <= 2'd0;
            asm_reg       <= 32'h0;
`ifdef INST_MEM_CHECKSUM_EN
            sum_reg       <= 32'h0;
`endif
        end else begin
            valid_reg     <= fetch_en;
            fetch_hit_reg <= fetch_en && !fetch_oor;
            done_reg      <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ld_start_i) begin
                        state_reg <= ST_LOAD;
                        ready_reg <= 1'b1;
                        ptr_reg   <= '0;
                        cnt_reg   <= 2'd0;
                        asm_reg   <= 32'h0;
                        ovf_reg   <= 1'b0;
`ifdef INST_MEM_CHECKSUM_EN
                        sum_reg   <= 32'h0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + 2'd1;
                        asm_reg <= word_next;
                        if (wr_word) begin
                            // Pointer saturates at DEPTH; further words are drained, not stored.
                            if (ram_full) begin
                                ovf_reg <= 1'b1;
                            end else begin
                                ptr_reg <= ptr_reg + PTR_ONE;
`ifdef INST_MEM_CHECKSUM_EN
                                sum_reg <= sum_reg + word_next;
`endif
                            end
                        end
                        if (ld_last_i) begin
                            state_reg <= ST_DONE;
                            ready_reg <= 1'b0;
                            done_reg  <= 1'b1;
                            cnt_reg   <= 2'd0;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    assign inst_o     = fetch_hit_reg ? ram_rd_reg : 32'h0;
    assign valid_o    = valid_reg;
    assign ld_ready_o = ready_reg;
    assign ld_done_o  = done_reg;
    assign ld_words_o = ptr_reg;
    assign ld_ovf_o   = ovf_reg;
`ifdef INST_MEM_CHECKSUM_EN
    assign ld_sum_o   = sum_reg;
`endif

endmodule
